// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: pc width, default
// return-stack depth, reset vector and the per-cycle action encoding.
package pc_pkg;

    localparam int              PC_W              = 10;
    localparam int              STACK_DEPTH_DEF   = 8;
    localparam logic [PC_W-1:0] RESET_VECTOR_DEF  = 10'd0;

    // One action is taken per unstalled clock edge.
    typedef enum logic [1:0] {
        ACT_SEQ  = 2'd0,
        ACT_CALL = 2'd1,
        ACT_RET  = 2'd2
    } action_e;

    // Next sequential address; natural 10-bit wrap takes 1023 to 0.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Only the occupancy counter is reset; entry contents
// are don't-care until written. Push is ignored when full, pop when empty.
import pc_pkg::*;

module ret_stack #(
    parameter int DEPTH = STACK_DEPTH_DEF,
    parameter int W     = PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // DEPTH is a power of two, so the low counter bits index the array and
    // the entry below the write slot is the top of stack.
    assign wr_idx = cnt_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign top    = mem_q[rd_idx];
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));

    // Next occupancy: push has priority, both are guarded against over/underflow.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !full) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Occupancy register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage, written on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return stack.
// Optional macro PC_STACK_ERR_EN: when defined, stack_err is a sticky
// overflow/underflow flag; when undefined, stack_err is tied low.
import pc_pkg::*;

module pc_sequencer #(
    parameter int              STACK_DEPTH  = STACK_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic            CLK,
    input  logic            RESET_n,
    input  logic            hold,
    input  logic            bsr_det,
    input  logic            ret_det,
    input  logic [PC_W-1:0] relative_jump,
    output logic [PC_W-1:0] pc,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            stack_err
);

    action_e         act;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] stk_top;
    logic            do_push;
    logic            do_pop;

    // Decode the action for this edge: call beats return beats sequential.
    always_comb begin
        act = ACT_SEQ;
        if (bsr_det) begin
            act = ACT_CALL;
        end else if (ret_det) begin
            act = ACT_RET;
        end
    end

    assign do_push = !hold && (act == ACT_CALL) && !stack_full;
    assign do_pop  = !hold && (act == ACT_RET)  && !stack_empty;

    // Next pc: rejected calls/returns fall through to pc+1.
    always_comb begin
        pc_d = pc_inc(pc_q);
        if (hold) begin
            pc_d = pc_q;
        end else if (do_push) begin
            pc_d = pc_q + relative_jump;
        end else if (do_pop) begin
            pc_d = stk_top;
        end
    end

    // Program counter register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk       (CLK),
        .rst_n     (RESET_n),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_inc(pc_q)),
        .top       (stk_top),
        .empty     (stack_empty),
        .full      (stack_full)
    );

`ifdef PC_STACK_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set = !hold && (((act == ACT_CALL) && stack_full) ||
                               ((act == ACT_RET)  && stack_empty));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (STACK_DEPTH=8, RESET_VECTOR=0).
module tb_pc_sequencer;

    logic       CLK;
    logic       RESET_n;
    logic       hold;
    logic       bsr_det;
    logic       ret_det;
    logic [9:0] relative_jump;
    logic [9:0] pc;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int vectors;
    int miscompares;

`ifdef PC_STACK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    pc_sequencer #(
        .STACK_DEPTH  (8),
        .RESET_VECTOR (10'd0)
    ) dut (
        .CLK           (CLK),
        .RESET_n       (RESET_n),
        .hold          (hold),
        .bsr_det       (bsr_det),
        .ret_det       (ret_det),
        .relative_jump (relative_jump),
        .pc            (pc),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .stack_err     (stack_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [9:0] epc,
                               input logic eempty, input logic efull, input logic eerr);
        check({tag, ".pc"},    {22'd0, pc},          {22'd0, epc});
        check({tag, ".empty"}, {31'd0, stack_empty}, {31'd0, eempty});
        check({tag, ".full"},  {31'd0, stack_full},  {31'd0, efull});
        check({tag, ".err"},   {31'd0, stack_err},   {31'd0, eerr});
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset pulse between edges, released on a falling edge.
    task automatic pulse_reset(input string tag);
        #2;
        RESET_n = 1'b0;
        #1;
        check_state(tag, 10'd0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        RESET_n       = 1'b1;
        hold          = 1'b0;
        bsr_det       = 1'b0;
        ret_det       = 1'b0;
        relative_jump = 10'd0;

        // Reset state
        #1 RESET_n = 1'b0;
        #1;
        check_state("reset", 10'd0, 1'b1, 1'b0, 1'b0);
        run(2);
        check_state("reset_held", 10'd0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        RESET_n = 1'b1;

        // Sequential counting after release
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("seq.pc", {22'd0, pc}, i);
            check("seq.empty", {31'd0, stack_empty}, 32'd1);
        end
        run(5);
        check("seq10.pc", {22'd0, pc}, 32'd10);

        // Call then return
        bsr_det = 1'b1; relative_jump = 10'd20;
        tick();
        check_state("call30", 10'd30, 1'b0, 1'b0, 1'b0);
        bsr_det = 1'b0; ret_det = 1'b1;
        tick();
        check_state("ret11", 10'd11, 1'b1, 1'b0, 1'b0);

        // Call and return together: call wins, no error
        bsr_det = 1'b1; ret_det = 1'b1; relative_jump = 10'd5;
        tick();
        check_state("both", 10'd16, 1'b0, 1'b0, 1'b0);
        bsr_det = 1'b0;
        tick();
        check_state("both_ret", 10'd12, 1'b1, 1'b0, 1'b0);
        ret_det = 1'b0;

        // Hold freezes pc and depth
        bsr_det = 1'b1; relative_jump = 10'd100;
        tick();
        check_state("call112", 10'd112, 1'b0, 1'b0, 1'b0);
        hold = 1'b1; relative_jump = 10'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("hold", 10'd112, 1'b0, 1'b0, 1'b0);
        end
        hold = 1'b0; bsr_det = 1'b0; ret_det = 1'b1;
        tick();
        check_state("hold_ret", 10'd13, 1'b1, 1'b0, 1'b0);
        ret_det = 1'b0;

        // Eight nested calls fill the stack, ninth overflows
        bsr_det = 1'b1; relative_jump = 10'd2;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("nest.pc", {22'd0, pc}, 32'(13 + 2 * k));
            check("nest.full", {31'd0, stack_full}, (k == 8) ? 32'd1 : 32'd0);
            check("nest.err", {31'd0, stack_err}, 32'd0);
        end
        tick();
        check_state("overflow", 10'd30, 1'b0, 1'b1, ERR_EN);
        bsr_det = 1'b0; ret_det = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("unwind.pc", {22'd0, pc}, 32'(28 - 2 * k));
            check("unwind.empty", {31'd0, stack_empty}, (k == 7) ? 32'd1 : 32'd0);
            check("unwind.full", {31'd0, stack_full}, 32'd0);
        end
        tick();
        check_state("underflow_after_ovf", 10'd15, 1'b1, 1'b0, ERR_EN);
        ret_det = 1'b0;
        run(2);
        check_state("err_sticky", 10'd17, 1'b1, 1'b0, ERR_EN);

        // Asynchronous reset mid-call clears everything
        bsr_det = 1'b1; relative_jump = 10'd50;
        pulse_reset("reset_mid");
        bsr_det = 1'b0;
        tick();
        check_state("post_reset", 10'd1, 1'b1, 1'b0, 1'b0);

        // Return on empty stack at pc=40
        run(39);
        check("pc40", {22'd0, pc}, 32'd40);
        ret_det = 1'b1;
        tick();
        check_state("underflow40", 10'd41, 1'b1, 1'b0, ERR_EN);
        ret_det = 1'b0;

        // Call wrapping past 1023, then sequential wrap
        pulse_reset("reset_wrap");
        run(1020);
        check("pc1020", {22'd0, pc}, 32'd1020);
        bsr_det = 1'b1; relative_jump = 10'd10;
        tick();
        check_state("wrap_call", 10'd6, 1'b0, 1'b0, 1'b0);
        bsr_det = 1'b0; ret_det = 1'b1;
        tick();
        check_state("wrap_ret", 10'd1021, 1'b1, 1'b0, 1'b0);
        ret_det = 1'b0;
        run(2);
        check("pc1023", {22'd0, pc}, 32'd1023);
        tick();
        check("wrap_seq", {22'd0, pc}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
